// File: rtl/double_ask_frame_rx.sv
// double_ask_frame_rx: framed 2ASK receiver, integrate-and-dump bit decisions over SPB-sample windows
module double_ask_frame_rx #(
  parameter int SPB = 64,
  parameter int DETECT_LEVEL = 4096,
  parameter int ENERGY_THRESH = 333000,
  parameter int ACC_W = 32
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic [15:0] rx_signal,
  output logic [15:0] data_out,
  output logic        data_valid,
  output logic        frame_err,
  output logic        busy
);
  localparam int CW = $clog2(SPB);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  state_t state, state_d;
  logic [ACC_W-1:0] acc, acc_d, sum;
  logic [CW-1:0] cnt, cnt_d;
  logic [4:0] bit_cnt, bit_cnt_d;
  logic [15:0] shreg, shreg_d, data_d, mag;
  logic detect, win_end, bit_one, valid_d, err_d;
  assign mag = rx_signal[15] ? (rx_signal == 16'h8000 ? 16'h7fff : -rx_signal) : rx_signal;
  assign sum = acc + ACC_W'(mag);
  assign detect = mag > 16'(DETECT_LEVEL);
  assign win_end = cnt == CW'(SPB - 1);
  assign bit_one = sum >= ACC_W'(ENERGY_THRESH);
  always_comb begin
    state_d = state;
    acc_d = sum;
    cnt_d = cnt + CW'(1);
    bit_cnt_d = bit_cnt;
    shreg_d = shreg;
    data_d = data_out;
    valid_d = 1'b0;
    err_d = 1'b0;
    if (state == IDLE) begin
      state_d = detect ? START : IDLE;
      acc_d = detect ? ACC_W'(mag) : '0;
      cnt_d = detect ? CW'(1) : '0;
    end else if (win_end) begin
      acc_d = '0;
      cnt_d = '0;
      case (state)
        START: begin
          state_d = bit_one ? DATA : IDLE;
          bit_cnt_d = '0;
        end
        DATA: begin
          shreg_d = {shreg[14:0], bit_one};
          bit_cnt_d = bit_cnt + 5'd1;
          state_d = bit_cnt == 5'd15 ? STOP : DATA;
        end
        default: begin
          state_d = IDLE;
          valid_d = !bit_one;
          err_d = bit_one;
          data_d = bit_one ? data_out : shreg;
        end
      endcase
    end
  end
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state <= IDLE;
      acc <= '0;
      cnt <= '0;
      bit_cnt <= '0;
      shreg <= '0;
      data_out <= '0;
      data_valid <= 1'b0;
      frame_err <= 1'b0;
      busy <= 1'b0;
    end else begin
      state <= state_d;
      acc <= acc_d;
      cnt <= cnt_d;
      bit_cnt <= bit_cnt_d;
      shreg <= shreg_d;
      data_out <= data_d;
      data_valid <= valid_d;
      frame_err <= err_d;
      busy <= state_d != IDLE;
    end
  end
endmodule

// File: tb/tb_double_ask_frame_rx.sv
// tb_double_ask_frame_rx: table vectors, corner sequences and a random stream checked against a window-sum model
module tb_double_ask_frame_rx;
  localparam int SPB = 64;
  localparam int DETECT_LEVEL = 4096;
  localparam int ENERGY_THRESH = 333000;
  localparam int FRAME = 18 * SPB;
  typedef struct {
    logic [15:0] word;
    bit stop_on;
    bit neg;
    int gap;
    bit exp_valid;
    bit exp_err;
    logic [15:0] exp_data;
  } vec_t;
  typedef struct {
    int cyc;
    bit err;
    logic [15:0] data;
  } ev_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [15:0] rx_signal = '0;
  logic [15:0] data_out;
  logic data_valid, frame_err, busy;
  int passed = 0;
  int total = 0;
  int g = 0;
  int both = 0;
  int stream[$];
  ev_t obs[$];
  logic [15:0] model_word = '0;
  int sine[8] = '{0, 11585, 16384, 11585, 0, -11585, -16384, -11585};
  vec_t vecs[6];
  double_ask_frame_rx #(
    .SPB(SPB), .DETECT_LEVEL(DETECT_LEVEL), .ENERGY_THRESH(ENERGY_THRESH), .ACC_W(32)
  ) dut (
    .sys_clk(clk), .sys_rst(rst), .rx_signal(rx_signal),
    .data_out(data_out), .data_valid(data_valid), .frame_err(frame_err), .busy(busy)
  );
  always #5 clk = ~clk;
  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got 'h%0h expected 'h%0h", name, act, exp);
  endtask
  function automatic int mag_of(input int s);
    int m = s < 0 ? -s : s;
    return m > 32767 ? 32767 : m;
  endfunction
  task automatic drive(input int s);
    stream.push_back(s);
    rx_signal = 16'(s);
    @(posedge clk);
    #1;
    if (data_valid && frame_err) both++;
    if (data_valid || frame_err) obs.push_back('{cyc: g + 1, err: frame_err, data: data_out});
    g++;
  endtask
  task automatic send_frame(input logic [15:0] word, input bit stop_on, input bit neg,
                            input int amp, input bit noise, input int nlim);
    for (int b = 0; b < 18; b++) begin
      logic v;
      v = b == 0 ? 1'b1 : b == 17 ? stop_on : word[16 - b];
      for (int j = 0; j < SPB; j++) begin
        if (b * SPB + j >= nlim) return;
        if (v) drive(neg ? -32768 : sine[(j + 1) % 8] * amp / 16384);
        else drive(noise ? int'($urandom_range(8000)) - 4000 : 0);
      end
    end
  endtask
  task automatic do_reset(input string tag);
    rst = 1'b1;
    rx_signal = 16'h4000;
    @(posedge clk);
    #1;
    check({tag, "_data_out"}, data_out, 0);
    check({tag, "_data_valid"}, data_valid, 0);
    check({tag, "_frame_err"}, frame_err, 0);
    check({tag, "_busy"}, busy, 0);
    rst = 1'b0;
    g = 0;
    both = 0;
    stream.delete();
    obs.delete();
    model_word = '0;
  endtask
  task automatic check_events(input string tag);
    ev_t exp_q[$];
    int i = 0;
    int n = stream.size();
    while (i < n) begin
      int bits[18];
      logic [15:0] w;
      if (mag_of(stream[i]) <= DETECT_LEVEL) begin
        i++;
        continue;
      end
      if (i + FRAME > n) break;
      for (int k = 0; k < 18; k++) begin
        int s = 0;
        for (int j = 0; j < SPB; j++) s += mag_of(stream[i + k * SPB + j]);
        bits[k] = s >= ENERGY_THRESH ? 1 : 0;
      end
      if (bits[0] == 0) begin
        i += SPB;
        continue;
      end
      w = '0;
      for (int k = 1; k <= 16; k++) w = {w[14:0], bits[k] == 1};
      if (bits[17] == 0) model_word = w;
      exp_q.push_back('{cyc: i + FRAME, err: bits[17] == 1, data: model_word});
      i += FRAME;
    end
    check({tag, "_event_count"}, obs.size(), exp_q.size());
    check({tag, "_valid_err_exclusive"}, both, 0);
    for (int k = 0; k < exp_q.size() && k < obs.size(); k++) begin
      check($sformatf("%s_ev%0d_cycle", tag, k), obs[k].cyc, exp_q[k].cyc);
      check($sformatf("%s_ev%0d_err", tag, k), obs[k].err, exp_q[k].err);
      check($sformatf("%s_ev%0d_data", tag, k), obs[k].data, exp_q[k].data);
    end
    g = 0;
    both = 0;
    stream.delete();
    obs.delete();
  endtask
  initial begin
    int g0, fall;
    vecs[0] = '{16'hA5C3, 1'b0, 1'b0, 5, 1'b1, 1'b0, 16'hA5C3};
    vecs[1] = '{16'h1234, 1'b1, 1'b0, 3, 1'b0, 1'b1, 16'hA5C3};
    vecs[2] = '{16'hFFFF, 1'b0, 1'b0, 0, 1'b1, 1'b0, 16'hFFFF};
    vecs[3] = '{16'h0001, 1'b0, 1'b1, 0, 1'b1, 1'b0, 16'h0001};
    vecs[4] = '{16'h0000, 1'b0, 1'b0, 7, 1'b1, 1'b0, 16'h0000};
    vecs[5] = '{16'h8001, 1'b1, 1'b0, 2, 1'b0, 1'b1, 16'h0000};
    do_reset("reset");
    for (int i = 0; i < 100; i++) drive(0);
    check("idle_data_out", data_out, 0);
    check("idle_data_valid", data_valid, 0);
    check("idle_frame_err", frame_err, 0);
    check("idle_busy", busy, 0);
    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < vecs[r].gap; i++) drive(0);
      send_frame(vecs[r].word, vecs[r].stop_on, vecs[r].neg, 16384, 1'b0, FRAME);
      check($sformatf("vec%0d_valid", r), data_valid, vecs[r].exp_valid);
      check($sformatf("vec%0d_err", r), frame_err, vecs[r].exp_err);
      check($sformatf("vec%0d_data", r), data_out, vecs[r].exp_data);
    end
    for (int i = 0; i < 10; i++) drive(0);
    g0 = g;
    drive(8000);
    check("spike_busy_rise", busy, 1);
    fall = -1;
    for (int i = 0; i < 100; i++) begin
      drive(0);
      if (fall < 0 && !busy) fall = g;
    end
    check("spike_busy_len", fall - g0, SPB);
    for (int f = 0; f < 30; f++) begin
      int gap = int'($urandom_range(30));
      for (int i = 0; i < gap; i++) drive(int'($urandom_range(8000)) - 4000);
      if ($urandom_range(5) == 0) begin
        drive($urandom_range(1) ? 8000 : -8000);
        for (int i = 0; i < int'($urandom_range(80)); i++) drive(0);
      end
      send_frame(16'($urandom), $urandom_range(4) == 0, $urandom_range(3) == 0,
                 int'($urandom_range(32767, 7000)), 1'b1, FRAME);
    end
    for (int i = 0; i < 1300; i++) drive(0);
    check_events("main");
    send_frame(16'h3C5A, 1'b0, 1'b0, 16384, 1'b0, 8 * SPB + 10);
    check_events("abort");
    do_reset("midframe_reset");
    for (int i = 0; i < 10; i++) drive(0);
    send_frame(16'h00FF, 1'b0, 1'b0, 16384, 1'b0, FRAME);
    check("post_reset_valid", data_valid, 1);
    check("post_reset_err", frame_err, 0);
    check("post_reset_data", data_out, 16'h00FF);
    for (int i = 0; i < 50; i++) drive(0);
    check_events("post_reset");
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
